// File: rtl/hit_storage_engine.sv
// hit_storage_engine: per-SSID hit bitmap, hit count/block base and hit-info storage with readout; optional counters under HIT_STORE_STATS_EN
module hit_storage_engine #(
    parameter int SSID_BITS    = 12,
    parameter int COL_BITS     = 5,
    parameter int HITINFO_BITS = 16,
    parameter int MAX_HITS     = 4,
    parameter int NBLOCKS      = 256,
    parameter int COUNT_BITS   = $clog2(MAX_HITS + 1)
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        clear_mem_i,
    output logic                        clear_busy_o,
    input  logic                        hit_valid_i,
    output logic                        hit_ready_o,
    input  logic [SSID_BITS-1:0]        hit_ssid_i,
    input  logic [HITINFO_BITS-1:0]     hit_info_i,
    input  logic                        rd_req_i,
    output logic                        rd_ready_o,
    input  logic [SSID_BITS-1:0]        rd_ssid_i,
    input  logic [$clog2(MAX_HITS)-1:0] rd_index_i,
    output logic                        rd_valid_o,
    output logic                        rd_hit_o,
    output logic [COUNT_BITS-1:0]       rd_count_o,
    output logic [HITINFO_BITS-1:0]     rd_info_o,
    output logic                        overflow_flag_o,
    output logic                        full_flag_o
`ifdef HIT_STORE_STATS_EN
    ,
    output logic [15:0]                 stat_hits_stored_o,
    output logic [15:0]                 stat_ssids_o,
    output logic [15:0]                 stat_dropped_o
`endif
);
    localparam int RB    = SSID_BITS - COL_BITS;
    localparam int BB    = $clog2(NBLOCKS);
    localparam int IB    = $clog2(MAX_HITS);
    localparam int CW    = BB + COUNT_BITS;
    localparam int COLS  = 1 << COL_BITS;
    localparam int NROWS = 1 << RB;

    typedef enum logic [1:0] {CLEAR, IDLE, WRITE, READ} state_t;

    logic [COLS-1:0]         bm_mem   [NROWS];
    logic [CW-1:0]           cnt_mem  [1 << SSID_BITS];
    logic [HITINFO_BITS-1:0] info_mem [NBLOCKS * MAX_HITS];

    state_t                  state_q, state_d;
    logic [RB-2:0]           clr_q, clr_d;
    logic                    pend_q, pend_d, ovf_q, ovf_d, full_q, full_d;
    logic [BB:0]             nb_q, nb_d;
    logic [SSID_BITS-1:0]    s1_ssid_q, s1_ssid_d, f_ssid_q, f_ssid_d, rs_q, rs_d;
    logic [HITINFO_BITS-1:0] s1_info_q, s1_info_d, rinf_q, rinf_d, info_rd_q;
    logic                    f_valid_q, f_valid_d, rv_q, rv_d, rh_q, rh_d;
    logic [COLS-1:0]         f_bits_q, f_bits_d, bm_rd_q, cur_bits, new_bits;
    logic [CW-1:0]           f_cnt_q, f_cnt_d, cnt_rd_q, cur_cnt, new_cnt;
    logic [1:0]              ph_q, ph_d;
    logic [IB-1:0]           ri_q, ri_d;
    logic [COUNT_BITS-1:0]   rc_q, rc_d, cur_n;
    logic [BB-1:0]           cur_base;
    logic [BB+IB-1:0]        info_wa, info_ra;
    logic [SSID_BITS-1:0]    ra;
    logic                    hit_acc, rd_acc, wr, cur_bit, alloc, store, drop, info_we;

    // next state: write-pipeline stage 1 with one-cycle forwarding, readout sequencing, clear sweep
    always_comb begin
        state_d     = state_q;
        clr_d       = clr_q;
        pend_d      = (state_q != CLEAR) && (pend_q || clear_mem_i);
        s1_ssid_d   = s1_ssid_q;
        s1_info_d   = s1_info_q;
        rs_d        = rs_q;
        ri_d        = ri_q;
        ph_d        = ph_q;
        rv_d        = 1'b0;
        rh_d        = rh_q;
        rc_d        = rc_q;
        rinf_d      = rinf_q;
        hit_ready_o = (state_q == IDLE || state_q == WRITE) && !pend_q;
        rd_ready_o  = state_q == IDLE && !pend_q && !hit_valid_i;
        hit_acc     = hit_valid_i && hit_ready_o;
        rd_acc      = rd_req_i && rd_ready_o;
        ra          = state_q == READ ? rs_q : hit_ssid_i;
        info_ra     = {cnt_rd_q[CW-1:COUNT_BITS], ri_q};
        wr          = state_q == WRITE;
        cur_bits    = (f_valid_q && f_ssid_q[SSID_BITS-1:COL_BITS] == s1_ssid_q[SSID_BITS-1:COL_BITS]) ? f_bits_q : bm_rd_q;
        cur_cnt     = (f_valid_q && f_ssid_q == s1_ssid_q) ? f_cnt_q : cnt_rd_q;
        cur_bit     = cur_bits[s1_ssid_q[COL_BITS-1:0]];
        cur_base    = cur_cnt[CW-1:COUNT_BITS];
        cur_n       = cur_cnt[COUNT_BITS-1:0];
        alloc       = wr && !cur_bit && !nb_q[BB];
        store       = wr && cur_bit && cur_n < COUNT_BITS'(MAX_HITS);
        drop        = wr && !alloc && !store;
        info_we     = alloc || store;
        new_bits    = cur_bits | ({{(COLS-1){1'b0}}, alloc} << s1_ssid_q[COL_BITS-1:0]);
        new_cnt     = alloc ? {nb_q[BB-1:0], COUNT_BITS'(1)} : store ? {cur_base, COUNT_BITS'(cur_n + 1'b1)} : cur_cnt;
        info_wa     = alloc ? {nb_q[BB-1:0], IB'(0)} : {cur_base, cur_n[IB-1:0]};
        nb_d        = alloc ? nb_q + 1'b1 : nb_q;
        full_d      = full_q || (drop && !cur_bit);
        ovf_d       = ovf_q || (drop && cur_bit);
        f_valid_d   = wr;
        f_ssid_d    = s1_ssid_q;
        f_bits_d    = new_bits;
        f_cnt_d     = new_cnt;
        case (state_q)
            CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (&clr_q) begin
                    state_d = IDLE;
                    nb_d    = '0;
                    ovf_d   = 1'b0;
                    full_d  = 1'b0;
                end
            end
            IDLE, WRITE: begin
                if (hit_acc) begin
                    state_d   = WRITE;
                    s1_ssid_d = hit_ssid_i;
                    s1_info_d = hit_info_i;
                end else if (state_q == IDLE && pend_q) begin
                    state_d = CLEAR;
                end else if (rd_acc) begin
                    state_d = READ;
                    rs_d    = rd_ssid_i;
                    ri_d    = rd_index_i;
                    ph_d    = 2'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                ph_d = ph_q + 1'b1;
                if (ph_q == 2'd1) begin
                    rh_d = bm_rd_q[rs_q[COL_BITS-1:0]];
                    rc_d = rh_d ? cnt_rd_q[COUNT_BITS-1:0] : '0;
                end
                if (ph_q == 2'd2) begin
                    rinf_d  = (rh_q && COUNT_BITS'(ri_q) < rc_q) ? info_rd_q : '0;
                    rv_d    = 1'b1;
                    ph_d    = 2'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // control and datapath registers; reset enters the clear sweep and drops anything in flight
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= CLEAR;
            clr_q     <= '0;
            pend_q    <= 1'b0;
            nb_q      <= '0;
            ovf_q     <= 1'b0;
            full_q    <= 1'b0;
            s1_ssid_q <= '0;
            s1_info_q <= '0;
            f_valid_q <= 1'b0;
            f_ssid_q  <= '0;
            f_bits_q  <= '0;
            f_cnt_q   <= '0;
            rs_q      <= '0;
            ri_q      <= '0;
            ph_q      <= '0;
            rv_q      <= 1'b0;
            rh_q      <= 1'b0;
            rc_q      <= '0;
            rinf_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            pend_q    <= pend_d;
            nb_q      <= nb_d;
            ovf_q     <= ovf_d;
            full_q    <= full_d;
            s1_ssid_q <= s1_ssid_d;
            s1_info_q <= s1_info_d;
            f_valid_q <= f_valid_d;
            f_ssid_q  <= f_ssid_d;
            f_bits_q  <= f_bits_d;
            f_cnt_q   <= f_cnt_d;
            rs_q      <= rs_d;
            ri_q      <= ri_d;
            ph_q      <= ph_d;
            rv_q      <= rv_d;
            rh_q      <= rh_d;
            rc_q      <= rc_d;
            rinf_q    <= rinf_d;
        end
    end

    // memories: registered reads, stage-1 writes, two bitmap rows zeroed per clear cycle
    always_ff @(posedge clock_i) begin
        bm_rd_q   <= bm_mem[ra[SSID_BITS-1:COL_BITS]];
        cnt_rd_q  <= cnt_mem[ra];
        info_rd_q <= info_mem[info_ra];
        if (state_q == CLEAR) begin
            bm_mem[{clr_q, 1'b0}] <= '0;
            bm_mem[{clr_q, 1'b1}] <= '0;
        end else if (wr) begin
            bm_mem[s1_ssid_q[SSID_BITS-1:COL_BITS]] <= new_bits;
        end
        if (wr) cnt_mem[s1_ssid_q] <= new_cnt;
        if (info_we) info_mem[info_wa] <= s1_info_q;
    end

    assign clear_busy_o    = state_q == CLEAR;
    assign rd_valid_o      = rv_q;
    assign rd_hit_o        = rh_q;
    assign rd_count_o      = rc_q;
    assign rd_info_o       = rinf_q;
    assign overflow_flag_o = ovf_q;
    assign full_flag_o     = full_q;

`ifdef HIT_STORE_STATS_EN
    logic [15:0] sh_q, sh_d, ss_q, ss_d, sd_q, sd_d;

    // saturating event counters, zeroed when a clear sweep finishes
    always_comb begin
        sh_d = sh_q + 16'(info_we && !(&sh_q));
        ss_d = ss_q + 16'(alloc && !(&ss_q));
        sd_d = sd_q + 16'(drop && !(&sd_q));
        if (state_q == CLEAR && &clr_q) begin
            sh_d = '0;
            ss_d = '0;
            sd_d = '0;
        end
    end

    // counter registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sh_q <= '0;
            ss_q <= '0;
            sd_q <= '0;
        end else begin
            sh_q <= sh_d;
            ss_q <= ss_d;
            sd_q <= sd_d;
        end
    end

    assign stat_hits_stored_o = sh_q;
    assign stat_ssids_o       = ss_q;
    assign stat_dropped_o     = sd_q;
`endif
endmodule

// File: doc/hit_storage_engine.md
Name: hit_storage_engine

Overview:
- Parametrised successor to the block-memory hit storage.
- Accepts a stream of (SSID, hit info) pairs and records three things per SSID:
  - whether the SSID was hit (hit-new bitmap);
  - hit count and allocated block base (count memory);
  - up to MAX_HITS hit-info words (hit-info memory, one block of MAX_HITS slots per hit SSID).
- Adds a valid/ready handshake, same-SSID forwarding at one hit per cycle, a readout port, and overflow/full reporting.
- Memories are inferred internally as simple dual-port RAMs with 1-cycle read latency.

Parameters:
- SSID_BITS, 12, SSID width.
- COL_BITS, 5, low SSID bits selecting the bit within a bitmap row; row width is 2^COL_BITS.
- HITINFO_BITS, 16, width of one hit-info word.
- MAX_HITS, 4, hit-info slots per SSID; must be a power of 2.
- NBLOCKS, 256, number of hit-info blocks (distinct SSIDs storable); must be a power of 2.
- COUNT_BITS, $clog2(MAX_HITS+1), width of stored count.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- clear_mem  in  1  pulse: start memory clear
- clear_busy  out  1  clear sweep in progress
- hit_valid  in  1  hit offered
- hit_ready  out  1  hit accepted when valid&ready
- hit_ssid  in  SSID_BITS  SSID of hit
- hit_info  in  HITINFO_BITS  hit payload
- rd_req  in  1  readout request, accepted when rd_req&rd_ready
- rd_ready  out  1  readout can be accepted
- rd_ssid  in  SSID_BITS  SSID to read
- rd_index  in  $clog2(MAX_HITS)  hit slot to read
- rd_valid  out  1  readout response strobe (1 cycle)
- rd_hit  out  1  SSID was hit since last clear
- rd_count  out  COUNT_BITS  stored hit count
- rd_info  out  HITINFO_BITS  hit info at rd_index (0 if rd_index >= rd_count)
- overflow_flag  out  1  sticky: a hit was dropped because its SSID already held MAX_HITS
- full_flag  out  1  sticky: a new SSID was dropped because all NBLOCKS are allocated

Behaviour:
- States: CLEAR, IDLE, WRITE, READ.
- Reset (async):
  - all registers cleared, state=CLEAR, clear_busy=1, hit_ready=0, rd_ready=0, rd_valid=0, flags=0.
  - Reset mid-operation discards in-flight hits and reads.
- CLEAR:
  - sweeps the bitmap, zeroing 2 rows per cycle (both RAM ports).
  - Duration is 2^(SSID_BITS-COL_BITS)/2 cycles (64 at defaults).
  - On the last row: next_block=0, flags cleared, then IDLE.
  - Count and hit-info memories are not swept; they are only valid where the bitmap bit is set.
- clear_mem sampled high in IDLE/WRITE/READ:
  - any hit in stage 1 or read in flight completes first;
  - CLEAR is entered the cycle after the pipeline drains.
  - clear_mem during CLEAR is ignored.
- hit_ready=1 in IDLE and WRITE unless clear is pending.
- rd_ready=1 only in IDLE with an empty write pipeline and no clear pending.
- Simultaneous hit_valid and rd_req in IDLE: hit wins, rd_ready drops.
- Write pipeline:
  - Stage 0 (accept): issue reads of bitmap row SSID[SSID_BITS-1:COL_BITS] and count entry SSID.
  - Stage 1 (one cycle later): compute and write.
  - Forwarding: if stage 1 row or SSID equals the entry written the previous cycle, use the forwarded written value, not RAM data. Back-to-back same-SSID and same-row hits must be exact.
  - Bit clear (new SSID):
    - if next_block < NBLOCKS: set bit; count=1; base=next_block; write info at base*MAX_HITS+0; next_block++.
    - else: drop and set full_flag.
  - Bit set (existing SSID):
    - if count < MAX_HITS: write info at base*MAX_HITS+count; count++.
    - else: drop and set overflow_flag; count saturates at MAX_HITS.
  - Throughput is 1 hit/cycle with no stalls outside CLEAR.
- Readout (READ state):
  - cycle 0: read bitmap and count;
  - cycle 1: read hit info at base*MAX_HITS+rd_index;
  - cycle 2: rd_valid=1 with rd_hit/rd_count/rd_info.
  - If the bit is clear: rd_hit=0, rd_count=0, rd_info=0.
  - Latency is 3 cycles; one read outstanding; back to IDLE after rd_valid.
- Width rules:
  - address arithmetic is unsigned;
  - block base field is $clog2(NBLOCKS) bits;
  - next_block is $clog2(NBLOCKS)+1 bits so the full condition is distinguishable.

Optional Feature:
- Macro HIT_STORE_STATS_EN.
- When defined, add three outputs, all 16-bit, saturating, zeroed by reset and at clear completion:
  - stat_hits_stored: hits written;
  - stat_ssids: blocks allocated;
  - stat_dropped: overflow drops plus full drops.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle → clear_busy=1 for 64 cycles; then hit_ready=1, rd_ready=1; read SSID 0x123 gives rd_hit=0, rd_count=0.
- Hits SSID 0x010 info 0xAAAA, then 0x010 info 0xBBBB on consecutive cycles → read idx0/1 gives count=2, 0xAAAA/0xBBBB (forwarding check).
- Consecutive hits 0x020 and 0x021 (same row), then read each → both rd_hit=1, count=1, and they are allocated distinct bases 0 and 1.
- Five hits to SSID 0x7FF → count=4, overflow_flag=1; read idx3 returns the 4th info; the 5th info is absent.
- 257 distinct SSIDs → full_flag=1, the 257th reads rd_hit=0; then clear_mem → after 64 cycles the flags are 0 and all previous SSIDs read rd_hit=0.
- clear_mem asserted while a hit is in stage 1, and reset asserted mid-readout → the hit completes before clear_busy rises; reset forces rd_valid=0 immediately and re-enters CLEAR.
